pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of register stages; WIDTH mod STAGES == 0 required; SEG = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand transfer offered.
REQ-006 SHALL have port in_ready  output  1  stage 0 can accept.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in, used when sub=0.
REQ-010 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out of MSB (no-borrow flag when sub=1).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-017 SHALL compute add: {cout,sum} = a + b + cin; subtract: {cout,sum} = a + ~b + 1, cin ignored.
REQ-018 SHALL compute ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), b_eff = sub ? ~b : b.
REQ-019 SHALL let stage k (0..STAGES-1) add segment k bits [SEG*k +: SEG] with the carry registered by stage k-1 (stage 0: cin or 1), registering its SEG sum bits and carry.
REQ-020 SHALL carry operand segments above k forward in skew registers and completed sum segments forward in deskew registers, so all bits of one result exit together.
REQ-021 SHALL produce a result exactly STAGES cycles after acceptance with no backpressure; throughput one result per cycle.
REQ-022 SHALL hold per-stage valid bits; stage k advances when !valid[k] || ready[k+1]; ready[STAGES] = out_ready; in_ready = ready[0].
REQ-023 SHALL collapse bubbles: an empty stage accepts even while later stages stall.
REQ-024 SHALL keep sum, cout, ovf stable while out_valid && !out_ready.
REQ-025 SHALL allow simultaneous accept and emit in one cycle when the pipe is full and out_ready=1, with no loss or duplication.
REQ-026 SHALL keep in_ready combinational from out_ready and valid bits (no registered skid).
REQ-027 SHALL give STAGES=1 a single-register ripple adder of latency 1 and SEG=WIDTH.
REQ-028 SHALL not change data registers of stages whose valid bit is 0 (hold data, no X propagation).

Reset
REQ-029 SHALL on rst_n=0 at a clock edge clear all valid bits; out_valid=0, sum=0, cout=0, ovf=0 next cycle.
REQ-030 SHALL discard in-flight operands on reset mid-operation; no result of a pre-reset transfer appears.
REQ-031 SHALL drive in_ready=1 from the first cycle after reset release.

Structure
REQ-032 SHALL place WIDTH/STAGES defaults and SEG derivation function in package pipelined_adder_pkg.
REQ-033 SHALL use one sub-module seg_adder (combinational SEG-bit ripple of full-adder cells: a, b, cin -> sum, cout), instantiated STAGES times via generate.
REQ-034 SHALL flag illegal WIDTH mod STAGES != 0 with an elaboration-time error.

Verification (WIDTH=32, STAGES=4)
REQ-035 SHALL check a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-036 SHALL check a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1.
REQ-037 SHALL check 16 back-to-back transfers with out_ready=1 -> 16 results on 16 consecutive cycles, in order, matching reference model.
REQ-038 SHALL check out_ready=0 for 3 cycles with pipe full -> in_ready=0, sum held stable, no loss when released.
REQ-039 SHALL check out_ready held 0 with one bubble in stage 1 -> in_ready stays 1 until bubble filled, then 0.
REQ-040 SHALL check rst_n=0 for one cycle with 3 results in flight -> out_valid=0 next cycle, zero results emitted before the next accepted transfer.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_pkg
// Purpose  : Shared defaults and the segment-width derivation used by the
//            pipelined adder and its per-stage segment adder.
// Contents : DEFAULT_WIDTH  - default operand/sum width in bits
//            DEFAULT_STAGES - default number of register stages
//            seg_width()    - bits handled by each stage (WIDTH / STAGES)
// Revision : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  // A zero stage count is trapped by an elaboration check in the top; the
  // guard here only keeps the constant function itself well defined.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/seg_adder.sv
`default_nettype none
// ============================================================================
// Module   : seg_adder
// Purpose  : Combinational WIDTH-bit ripple-carry adder built from full-adder
//            cells; one instance forms the arithmetic of each pipeline stage.
// Ports    : a, b  (in)  segment operands
//            cin   (in)  carry into bit 0
//            sum   (out) segment sum
//            cout  (out) carry out of the top bit
// Revision : 1.0 - initial release
// ============================================================================
module seg_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = seg_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The carry ripples through a procedural variable so that each cell's
  // carry-in is the previous cell's carry-out without a self-referencing
  // carry vector.
  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule : seg_adder
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : STAGES-deep carry-pipelined adder/subtractor with valid/ready
//            handshakes on both sides. Stage k adds bit segment k using the
//            carry registered by stage k-1; unprocessed operand segments ride
//            ahead in skew registers and finished sum segments follow in
//            deskew registers so a whole result leaves the last stage at once.
// Ports    : clk        (in)  clock, rising edge
//            rst_n      (in)  synchronous active-low reset
//            in_valid   (in)  operand transfer offered
//            in_ready   (out) stage 0 can accept
//            a, b       (in)  operands
//            cin        (in)  carry-in, ignored when subtracting
//            sub        (in)  0 = a+b+cin, 1 = a-b
//            out_valid  (out) result available
//            out_ready  (in)  downstream accepts result
//            sum        (out) result
//            cout       (out) carry out of MSB (no-borrow when subtracting)
//            ovf        (out) two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);
  localparam int unsigned MSB = WIDTH - 1;

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (STAGES == 0) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // --------------------------------------------------------------------------
  // Inter-stage views of each stage's registers
  // --------------------------------------------------------------------------
  logic [STAGES:0]   stage_ready;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [WIDTH-1:0]  stage_a   [STAGES];
  logic [WIDTH-1:0]  stage_b   [STAGES];
  logic [WIDTH-1:0]  stage_sum [STAGES];

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              ovf_d;
  logic              ovf_q;

  // Subtraction is a + ~b + 1: invert b once at the entrance and force the
  // stage-0 carry high, so every stage is a plain adder.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  // A stage may load when it is empty or its successor is loading too. The
  // chain is resolved in one procedural pass from the output backwards, which
  // lets an empty stage accept even while the stages after it are stalled.
  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] || stage_ready[k + 1];
    end
  end

  assign in_ready = stage_ready[0];

  // --------------------------------------------------------------------------
  // Pipeline stages
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    // Operand bits still waiting for a later stage; the last stage keeps none.
    localparam logic [WIDTH-1:0] c_HI_MASK = {WIDTH{1'b1}} << (SEG * (k + 1));

    logic             vin;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sin;
    logic             cin_k;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] sum_d, sum_q;

    if (k == 0) begin : g_first
      assign vin   = in_valid;
      assign ain   = a;
      assign bin   = b_eff;
      assign sin   = '0;
      assign cin_k = cin_eff;
    end else begin : g_next
      assign vin   = stage_valid[k - 1];
      assign ain   = stage_a[k - 1];
      assign bin   = stage_b[k - 1];
      assign sin   = stage_sum[k - 1];
      assign cin_k = stage_carry[k - 1];
    end

    seg_adder #(
      .WIDTH (SEG)
    ) u_seg_adder (
      .a    (ain[SEG * k +: SEG]),
      .b    (bin[SEG * k +: SEG]),
      .cin  (cin_k),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    // Data registers only move when a valid item is loaded; a stage that is
    // drained keeps its last contents, so no stale or unknown data moves.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      if (stage_ready[k]) begin
        valid_d = vin;
        if (vin) begin
          a_d                  = ain & c_HI_MASK;
          b_d                  = bin & c_HI_MASK;
          sum_d                = sin;
          sum_d[SEG * k +: SEG] = seg_sum;
          carry_d              = seg_cout;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_carry[k] = carry_q;
    assign stage_a[k]     = a_q;
    assign stage_b[k]     = b_q;
    assign stage_sum[k]   = sum_q;

    // The operand MSBs arrive with the top segment, so overflow is settled
    // by the final stage alongside the top sum bit.
    if (k == int'(STAGES) - 1) begin : g_ovf
      always_comb begin
        ovf_d = ovf_q;
        if (stage_ready[k] && vin) begin
          ovf_d = (ain[MSB] == bin[MSB]) && (seg_sum[SEG-1] != ain[MSB]);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid = stage_valid[STAGES-1];
  assign sum       = stage_sum[STAGES-1];
  assign cout      = stage_carry[STAGES-1];
  assign ovf       = ovf_q;

endmodule : pipelined_adder
`default_nettype wire
